// File: rtl/freq_meter.sv
// Multi-channel gated frequency counter: synchronises each input, counts qualifying
// edges over a fixed gate window and publishes saturating counts with a valid strobe.
`timescale 1ns/1ps

module freq_meter #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 80000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       meas_in,
  input  logic [CHANNELS-1:0]       edge_sel,
  input  logic                      gate_restart,
  output logic [CHANNELS*CNT_W-1:0] freq_out,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       stalled,
  output logic                      valid
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [GATE_W-1:0]                    gate_cnt_q, gate_cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       freq_q, freq_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_step;
  logic [CHANNELS-1:0]                  pend_q, pend_d, pend_step;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d;
  logic [CHANNELS-1:0]                  stall_q, stall_d;
  logic [CHANNELS-1:0]                  hit;
  logic                                 valid_q, valid_d;
  logic                                 terminal;

  // Bit 0 of each chain is the newest sample; edges are judged on the two oldest.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    logic newer, older, at_max;

    assign sync_d[n]     = {sync_q[n][SYNC_STAGES-2:0], meas_in[n]};
    assign newer         = sync_q[n][SYNC_STAGES-2];
    assign older         = sync_q[n][SYNC_STAGES-1];
    assign hit[n]        = (newer & ~older) | (edge_sel[n] & ~newer & older);
    assign at_max        = &edge_cnt_q[n];
    assign cnt_step[n]   = (hit[n] && !at_max) ? edge_cnt_q[n] + CNT_W'(1) : edge_cnt_q[n];
    assign pend_step[n]  = pend_q[n] | (hit[n] & at_max);
  end

  assign terminal = (gate_cnt_q == GATE_LAST);

  always_comb begin
    // NOTE: every signal gets a default first, so no branch can leave a latch behind.
    gate_cnt_d = terminal ? '0 : gate_cnt_q + GATE_W'(1);
    edge_cnt_d = cnt_step;
    pend_d     = pend_step;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    stall_d    = stall_q;
    valid_d    = 1'b0;

    if (gate_restart) begin
      // Restart beats the terminal cycle; the edge seen this cycle is dropped.
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      pend_d     = '0;
    end else if (terminal) begin
      freq_d     = cnt_step;
      ovf_d      = pend_step;
      for (int n = 0; n < CHANNELS; n++) begin
        stall_d[n] = (cnt_step[n] == '0);
      end
      edge_cnt_d = '0;
      pend_d     = '0;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      sync_q     <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      pend_q     <= '0;
      freq_q     <= '1;
      ovf_q      <= '0;
      stall_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      pend_q     <= pend_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      stall_q    <= stall_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign stalled  = stall_q;
  assign valid    = valid_q;

endmodule

// File: doc/freq_meter.md
# freq_meter

Multi-channel gated frequency counter in the `clk` domain. Each channel synchronises an asynchronous input, counts its edges over a common gate window of `GATE_CYCLES` clocks, and publishes the per-window count together with a one-cycle `valid` strobe. It replaces the single-channel SNES sysclk measurement with a generalised block. It adds per-channel edge mode, saturation and overflow reporting, stall detection, and a gate restart. Results are read by the MCU register file.

## Interface
Parameters:
- `CHANNELS`, 2: number of measured inputs.
- `CNT_W`, 32: width of each edge counter and result.
- `GATE_CYCLES`, 80000000: gate window length in `clk` cycles, ≥ 4.
- `SYNC_STAGES`, 2: synchroniser depth, ≥ 2.

Ports:
- `clk` in 1: system clock. Single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `meas_in` in `CHANNELS`: asynchronous signals to measure.
- `edge_sel` in `CHANNELS`: per channel; 0 counts rising edges only, 1 counts both edges.
- `gate_restart` in 1: single-cycle pulse that aborts the current window and starts a new one.
- `freq_out` out `CHANNELS*CNT_W`: last published counts. Channel n occupies `[n*CNT_W +: CNT_W]`.
- `overflow` out `CHANNELS`: the published count for that channel saturated.
- `stalled` out `CHANNELS`: the published count for that channel is 0.
- `valid` out 1: one-cycle strobe that marks a new publication.

## Operation
- **Synchroniser.** Each `meas_in[n]` passes through a `SYNC_STAGES`-deep flop chain. The edge detector compares the last two stages:
  - Rising edge: 0→1.
  - Falling edge: 1→0, counted only when `edge_sel[n]` = 1.
  - `edge_sel` is sampled in the same cycle as the detection.
- **Gate counter.** Counts 0..`GATE_CYCLES`-1 and wraps to 0. The terminal cycle is `gate_cnt == GATE_CYCLES-1`.
- **Edge counter (per channel).**
  - Increments by 1 for each cycle in which a qualifying edge is detected.
  - Saturates at 2^`CNT_W`-1. It never wraps.
  - A sticky per-channel overflow-pending bit is set when an increment is requested while the counter is already at maximum.
- **Terminal cycle, no restart.** On the next edge:
  - `freq_out[n]` ← edge count including any edge detected in the terminal cycle.
  - `overflow[n]` ← pending bit.
  - `stalled[n]` ← (published count == 0).
  - `valid` ← 1.
  - Edge counters and pending bits clear to 0.
  - The window therefore spans exactly `GATE_CYCLES` detection cycles; no edge is lost or double-counted across the boundary.
- **`gate_restart`.**
  - Clears the gate counter, edge counters and pending bits.
  - `freq_out`, `overflow` and `stalled` hold their values, and no `valid` is produced.
  - An edge detected in the restart cycle is discarded.
  - Edges still in the synchroniser are counted in the new window.
- **Restart and terminal cycle coincide.** Restart wins: no publication, and counters clear.
- **`rst`.** Has the same clearing effect as restart. In addition:
  - Synchroniser flops clear to 0.
  - `freq_out` = all ones (the "no measurement yet" sentinel).
  - `overflow` = 0, `stalled` = 0, `valid` = 0.
  - A reset mid-window discards that window.

## Timing
- All outputs are registered. `freq_out`, `overflow` and `stalled` change only in the cycle where `valid` = 1, or on `rst`.
- Latency from a `meas_in` transition to the edge being counted is `SYNC_STAGES`+1 clocks.
- The first `valid` after `rst` or `gate_restart` is deasserted asserts exactly `GATE_CYCLES` clocks after that cycle. Subsequent strobes follow every `GATE_CYCLES` clocks.
- `valid` is high for exactly 1 cycle.
- Inputs must be high and low for at least `SYNC_STAGES`+1 `clk` periods to count reliably. Faster inputs under-count; this is not flagged.
- The counters need no multi-cycle paths. The gate compare is against a constant.

## Test plan
Defaults for all scenarios: `GATE_CYCLES`=100, `CHANNELS`=2, `CNT_W`=8.

1. **Basic counting.** Release `rst`; ch0 toggles every 5 clocks, `edge_sel`=0; ch1 held at 0.
   - Required: `valid` at cycle 100.
   - `freq_out` ch0 = 10, ch1 = 0.
   - `stalled` = 2'b10, `overflow` = 0.
   - Before the first `valid`, `freq_out` reads 0xFF/0xFF.
2. **Both-edge mode.** Same ch0 stimulus with `edge_sel[0]`=1.
   - Required: ch0 = 20 per window, stable over 3 consecutive windows.
3. **Saturation.** Use `CNT_W`=4; ch0 toggles every 3 clocks with `edge_sel`=1 (~33 edges).
   - Required: ch0 = 15, `overflow[0]`=1.
   - Next window with ch0 idle: ch0 = 0, `overflow[0]`=0, `stalled[0]`=1.
4. **Boundary edge.** Arrange a rising edge to be detected exactly in the terminal cycle.
   - Required: that edge is counted in the current window, not the next one.
   - The sum over two windows equals the total number of edges driven.
5. **Restart.** Pulse `gate_restart` at cycle 60 of a window.
   - Required: no `valid` at cycle 100; the next `valid` comes 100 cycles after the pulse.
   - Outputs hold the previous values in between.
   - Repeat with the pulse in the terminal cycle: no `valid`.
6. **Reset mid-window.** Assert `rst` at cycle 50 for 1 cycle.
   - Required: all outputs return to their reset values, with `freq_out`=0xFF.
   - The next `valid` comes 100 cycles after `rst` is released.
